// File: rtl/fcvt_pkg.sv
// Shared constants for the integer-to-single rounding pipeline: rounding-mode
// encodings, fflags bit positions and the IEEE single field geometry.
package fcvt_pkg;

    // IEEE single geometry
    localparam int FCVT_F_EXP  = 8;
    localparam int FCVT_F_FLAC = 23;
    localparam int FCVT_BIAS   = 127;

    // RISC-V rounding modes (frm / instruction rm field)
    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    // fflags bit indices, vector order {NV,DZ,OF,UF,NX}
    localparam int FF_NX = 0;
    localparam int FF_UF = 1;
    localparam int FF_OF = 2;
    localparam int FF_DZ = 3;
    localparam int FF_NV = 4;

endpackage

// File: rtl/fcvt_rnd_inc.sv
// Round-increment decision: from the sign, the kept lsb and the guard/sticky
// bits, decide whether the kept fraction is bumped by one ulp and whether the
// conversion is inexact. Reserved modes 5..7 fall back to round-to-nearest-even.
module fcvt_rnd_inc
    import fcvt_pkg::*;
(
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       sticky,
    input  logic [2:0] rm,
    output logic       inc,
    output logic       nx
);

    // Mode-dependent increment; any discarded bit makes the result inexact
    always_comb begin
        nx = guard | sticky;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (guard | sticky);
            RM_RUP:  inc = ~sign & (guard | sticky);
            RM_RMM:  inc = guard;
            default: inc = guard & (sticky | lsb);
        endcase
    end

endmodule

// File: rtl/fcvt_round.sv
// Final rounding stage of the int64 -> single converter. Two registered
// stages with valid/ready handshakes:
//   S1 captures the kept fraction plus the round-up / inexact decision,
//   S2 applies the increment (with exponent bump on fraction carry-out)
//   and holds the packed IEEE result until writeback takes it.
// Build option FCVT_ALL_RM_EN: when defined, in_rm selects the rounding
// mode; when undefined, in_rm is ignored and round-to-nearest-even is used.
module fcvt_round
    import fcvt_pkg::*;
#(
    parameter int F_WIDTH = 32,
    parameter int F_EXP   = FCVT_F_EXP,
    parameter int F_FLAC  = FCVT_F_FLAC,
    parameter int M_WIDTH = 64
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic               in_zero,
    input  logic [F_EXP-1:0]   in_exp,
    input  logic [M_WIDTH-1:0] in_mant,
    input  logic [2:0]         in_rm,
    input  logic [4:0]         in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [F_WIDTH-1:0] out_data,
    output logic [4:0]         out_fflags,
    output logic [4:0]         out_tag
);

    // Bit positions of the kept lsb and the guard bit inside the mantissa
    localparam int LSB_POS = M_WIDTH - F_FLAC - 1;
    localparam int G_POS   = LSB_POS - 1;

    // Stage 1 registers
    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q,  s1_sign_d;
    logic              s1_zero_q,  s1_zero_d;
    logic [F_EXP-1:0]  s1_exp_q,   s1_exp_d;
    logic [F_FLAC-1:0] s1_frac_q,  s1_frac_d;
    logic              s1_inc_q,   s1_inc_d;
    logic              s1_nx_q,    s1_nx_d;
    logic [4:0]        s1_tag_q,   s1_tag_d;

    // Stage 2 (output) registers
    logic               out_valid_q,  out_valid_d;
    logic [F_WIDTH-1:0] out_data_q,   out_data_d;
    logic [4:0]         out_fflags_q, out_fflags_d;
    logic [4:0]         out_tag_q,    out_tag_d;

    logic              s2_adv;
    logic              s1_adv;
    logic              rnd_lsb;
    logic              rnd_guard;
    logic              rnd_sticky;
    logic [2:0]        rm_eff;
    logic              rnd_inc;
    logic              rnd_nx;
    logic [F_FLAC:0]   frac_sum;
    logic              frac_carry;
    logic [F_EXP-1:0]  exp_rnd;

    // The hidden 1 is implied by normalisation and never reaches the result
    logic unused_hidden;
    assign unused_hidden = in_mant[M_WIDTH-1];

`ifdef FCVT_ALL_RM_EN
    assign rm_eff = in_rm;
`else
    logic unused_rm;
    assign unused_rm = ^in_rm;
    assign rm_eff    = RM_RNE;
`endif

    // Handshake: a stage may load when its register is empty or draining
    always_comb begin
        s2_adv   = ~out_valid_q | out_ready;
        s1_adv   = ~s1_valid_q | s2_adv;
        in_ready = ~RST & s1_adv;
    end

    // Extract the round bits from the incoming normalised mantissa
    always_comb begin
        rnd_lsb    = in_mant[LSB_POS];
        rnd_guard  = in_mant[G_POS];
        rnd_sticky = |in_mant[G_POS-1:0];
    end

    fcvt_rnd_inc u_rnd_inc (
        .sign   (in_sign),
        .lsb    (rnd_lsb),
        .guard  (rnd_guard),
        .sticky (rnd_sticky),
        .rm     (rm_eff),
        .inc    (rnd_inc),
        .nx     (rnd_nx)
    );

    // S1 next state: capture the round decision when the stage advances
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_zero_d  = s1_zero_q;
        s1_exp_d   = s1_exp_q;
        s1_frac_d  = s1_frac_q;
        s1_inc_d   = s1_inc_q;
        s1_nx_d    = s1_nx_q;
        s1_tag_d   = s1_tag_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = in_sign;
                s1_zero_d = in_zero;
                s1_exp_d  = in_exp;
                s1_frac_d = in_mant[M_WIDTH-2:LSB_POS];
                s1_inc_d  = rnd_inc;
                s1_nx_d   = rnd_nx;
                s1_tag_d  = in_tag;
            end
        end
    end

    // Apply the increment; a fraction carry-out leaves frac_sum low bits at 0
    always_comb begin
        frac_sum   = {1'b0, s1_frac_q} + {{F_FLAC{1'b0}}, s1_inc_q};
        frac_carry = frac_sum[F_FLAC];
        exp_rnd    = s1_exp_q + {{(F_EXP-1){1'b0}}, frac_carry};
    end

    // S2 next state: pack the IEEE result; a zero source gives +0.0, no flags
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_fflags_d = out_fflags_q;
        out_tag_d    = out_tag_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_tag_d    = s1_tag_q;
                out_fflags_d = '0;
                if (s1_zero_q) begin
                    out_data_d = '0;
                end else begin
                    out_data_d          = {s1_sign_q, exp_rnd, frac_sum[F_FLAC-1:0]};
                    out_fflags_d[FF_NX] = s1_nx_q;
                end
            end
        end
    end

    // State registers with synchronous reset; reset drops in-flight entries
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_frac_q    <= '0;
            s1_inc_q     <= 1'b0;
            s1_nx_q      <= 1'b0;
            s1_tag_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_fflags_q <= '0;
            out_tag_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_zero_q    <= s1_zero_d;
            s1_exp_q     <= s1_exp_d;
            s1_frac_q    <= s1_frac_d;
            s1_inc_q     <= s1_inc_d;
            s1_nx_q      <= s1_nx_d;
            s1_tag_q     <= s1_tag_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_fflags_q <= out_fflags_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_fflags = out_fflags_q;
    assign out_tag    = out_tag_q;

endmodule
